// File: rtl/pipelined_oet_sorter_pkg.sv
// sort_pkg: shared defaults, element type and compare-swap helper for the OET sorter
package sort_pkg;
  localparam int DEF_N = 5;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAX_W = 64;
  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;
  function automatic logic [2*MAX_W-1:0] cmp_swap(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input logic desc);
    return (desc ? a < b : b < a) ? {b, a} : {a, b};
  endfunction
endpackage

// File: rtl/pipelined_oet_sorter_if.sv
// pipelined_oet_sorter_if: window stream in/out handshake bundle (in_bypass only with OET_SORTER_BYPASS_EN)
interface pipelined_oet_sorter_if import sort_pkg::*; #(parameter int N = DEF_N, parameter int DATA_WIDTH = DEF_DATA_WIDTH);
  logic in_valid, in_ready, in_desc, out_valid, out_ready;
  logic [N*DATA_WIDTH-1:0] in_data, out_data;
  logic [DATA_WIDTH-1:0] out_median;
`ifdef OET_SORTER_BYPASS_EN
  logic in_bypass;
  modport master(output in_valid, in_desc, in_data, in_bypass, out_ready, input in_ready, out_valid, out_data, out_median);
  modport slave(input in_valid, in_desc, in_data, in_bypass, out_ready, output in_ready, out_valid, out_data, out_median);
`else
  modport master(output in_valid, in_desc, in_data, out_ready, input in_ready, out_valid, out_data, out_median);
  modport slave(input in_valid, in_desc, in_data, out_ready, output in_ready, out_valid, out_data, out_median);
`endif
endinterface

// File: rtl/pipelined_oet_sorter_layer.sv
// oet_layer: one registered odd-even transposition layer carrying valid/desc/bypass beside the data
module oet_layer import sort_pkg::*; #(
  parameter int N = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_desc,
  input  logic in_byp,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic out_valid,
  output logic out_desc,
  output logic out_byp,
  output logic [N*DATA_WIDTH-1:0] out_data
);
  localparam int W = DATA_WIDTH;
  logic [N*W-1:0] nxt;
  for (genvar i = 0; i < N; i++) begin : g
    if (i % 2 == ODD && i + 1 < N) begin : g_pair
      logic [2*MAX_W-1:0] s;
      assign s = cmp_swap(MAX_W'(in_data[(N-i)*W-1 -: W]), MAX_W'(in_data[(N-i-1)*W-1 -: W]), in_desc);
      assign nxt[(N-i)*W-1 -: 2*W] = in_byp ? in_data[(N-i)*W-1 -: 2*W] : {W'(s[2*MAX_W-1:MAX_W]), W'(s[MAX_W-1:0])};
    end else if (i % 2 == ODD || i == 0) begin : g_pass
      assign nxt[(N-i)*W-1 -: W] = in_data[(N-i)*W-1 -: W];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_desc <= 1'b0;
      out_byp <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_desc <= in_desc;
      out_byp <= in_byp;
      out_data <= nxt;
    end
endmodule

// File: rtl/pipelined_oet_sorter.sv
// pipelined_oet_sorter: N-layer registered OET sort with backpressure and median tap (OET_SORTER_BYPASS_EN adds in_bypass)
module pipelined_oet_sorter import sort_pkg::*; #(
  parameter int N = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MED_IDX = (N - 1) / 2
) (
  input logic clk,
  input logic rst_n,
  pipelined_oet_sorter_if.slave bus
);
  localparam int W = DATA_WIDTH;
  logic stall, unused;
  logic [N:0] vld, dsc, byp;
  logic [N*W-1:0] dat [N+1];
  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign vld[0] = bus.in_valid;
  assign dsc[0] = bus.in_desc;
  assign dat[0] = bus.in_data;
`ifdef OET_SORTER_BYPASS_EN
  assign byp[0] = bus.in_bypass;
`else
  assign byp[0] = 1'b0;
`endif
  for (genvar k = 0; k < N; k++) begin : g_layer
    oet_layer #(.N(N), .DATA_WIDTH(W), .ODD(k % 2)) u_layer (
      .clk(clk), .rst_n(rst_n), .en(!stall),
      .in_valid(vld[k]), .in_desc(dsc[k]), .in_byp(byp[k]), .in_data(dat[k]),
      .out_valid(vld[k+1]), .out_desc(dsc[k+1]), .out_byp(byp[k+1]), .out_data(dat[k+1])
    );
  end
  // the last layer's order flags have no consumer
  assign unused = ^{dsc[N], byp[N]};
  assign bus.out_valid = vld[N];
  assign bus.out_data = dat[N];
  assign bus.out_median = dat[N][(N-MED_IDX)*W-1 -: W];
endmodule

// File: tb/tb_pipelined_oet_sorter.sv
// tb_pipelined_oet_sorter: directed table, reset, stall/scoreboard and N=2 checks for the OET sorter
module tb_pipelined_oet_sorter;
  import sort_pkg::*;
  localparam int N = 5;
  localparam int W = 8;
  typedef struct {
    string name;
    logic [N*W-1:0] din;
    logic desc;
    logic byp;
    logic [N*W-1:0] exp;
    logic [W-1:0] med;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  pipelined_oet_sorter_if #(.N(N), .DATA_WIDTH(W)) bus();
  pipelined_oet_sorter_if #(.N(2), .DATA_WIDTH(W)) bus2();
  pipelined_oet_sorter #(.N(N), .DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_oet_sorter #(.N(2), .DATA_WIDTH(W)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] ref_sort(input logic [N*W-1:0] w, input logic desc);
    elem_t a [N];
    elem_t t;
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) a[i] = w[(N-i)*W-1 -: W];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (desc ? a[j] < a[j+1] : a[j] > a[j+1]) begin
          t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
        end
    for (int i = 0; i < N; i++) r[(N-i)*W-1 -: W] = a[i];
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] cur, held;
    logic cur_desc, held_v;
    logic [N*W-1:0] q[$];
    logic [2*W-1:0] w2 [4];
    logic [2*W-1:0] e2 [4];
    logic [3:0] d2;
    int sent, recv, cyc, seen;
    vecs.push_back('{"asc", {8'd9, 8'd3, 8'd7, 8'd1, 8'd5}, 1'b0, 1'b0, {8'd1, 8'd3, 8'd5, 8'd7, 8'd9}, 8'd5});
    vecs.push_back('{"desc", {8'd9, 8'd3, 8'd7, 8'd1, 8'd5}, 1'b1, 1'b0, {8'd9, 8'd7, 8'd5, 8'd3, 8'd1}, 8'd5});
    vecs.push_back('{"ties_asc", {8'd4, 8'd4, 8'd4, 8'd0, 8'd255}, 1'b0, 1'b0, {8'd0, 8'd4, 8'd4, 8'd4, 8'd255}, 8'd4});
    vecs.push_back('{"ties_desc", {8'd4, 8'd4, 8'd4, 8'd0, 8'd255}, 1'b1, 1'b0, {8'd255, 8'd4, 8'd4, 8'd4, 8'd0}, 8'd4});
    vecs.push_back('{"extremes", {8'd255, 8'd254, 8'd1, 8'd0, 8'd128}, 1'b0, 1'b0, {8'd0, 8'd1, 8'd128, 8'd254, 8'd255}, 8'd128});
    vecs.push_back('{"rev_sorted", {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1'b1, 1'b0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd3});
`ifdef OET_SORTER_BYPASS_EN
    vecs.push_back('{"bypass", {8'd9, 8'd3, 8'd7, 8'd1, 8'd5}, 1'b0, 1'b1, {8'd9, 8'd3, 8'd7, 8'd1, 8'd5}, 8'd7});
    bus.in_bypass = 1'b0;
    bus2.in_bypass = 1'b0;
`endif
    bus.in_valid = 1'b0;
    bus.in_desc = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;
    bus2.in_desc = 1'b0;
    bus2.in_data = '0;
    bus2.out_ready = 1'b1;
    repeat (3) tick;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_median", bus.out_median, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);

    foreach (vecs[v]) begin
      bus.in_valid = 1'b1;
      bus.in_desc = vecs[v].desc;
      bus.in_data = vecs[v].din;
`ifdef OET_SORTER_BYPASS_EN
      bus.in_bypass = vecs[v].byp;
`endif
      tick;
      bus.in_valid = 1'b0;
      repeat (N - 2) tick;
      chk({vecs[v].name, "_early"}, bus.out_valid, 0);
      tick;
      chk({vecs[v].name, "_valid"}, bus.out_valid, 1);
      chk({vecs[v].name, "_data"}, bus.out_data, vecs[v].exp);
      chk({vecs[v].name, "_median"}, bus.out_median, vecs[v].med);
      tick;
      chk({vecs[v].name, "_one_cycle"}, bus.out_valid, 0);
    end
`ifdef OET_SORTER_BYPASS_EN
    bus.in_bypass = 1'b0;
`endif

    bus.in_valid = 1'b1;
    bus.in_desc = 1'b0;
    bus.in_data = {8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    tick;
    chk("midrst_hold_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (N + 3) begin
      tick;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_leftover", seen, 0);

    sent = 0;
    recv = 0;
    cyc = 0;
    held_v = 1'b0;
    held = '0;
    cur = {$urandom, 8'($urandom)};
    cur_desc = 1'($urandom);
    while ((sent < 20 || q.size() > 0) && cyc < 200) begin
      bus.in_valid = sent < 20;
      bus.in_data = cur;
      bus.in_desc = cur_desc;
      bus.out_ready = !(cyc >= 10 && cyc < 17);
      #1;
      if (held_v) begin
        chk("stall_valid_held", bus.out_valid, 1);
        chk("stall_data_held", bus.out_data, held);
      end
      held_v = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (held_v) chk("stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("stream_spurious", 1, 0);
        else chk("stream_order", bus.out_data, q.pop_front());
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_sort(cur, cur_desc));
        sent++;
        cur = {$urandom, 8'($urandom)};
        cur_desc = 1'($urandom);
      end
      tick;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", recv, 20);
    chk("stream_drained", q.size(), 0);
    chk("stream_no_bubble", cyc, 20 + N + 7);

    w2 = '{{8'd200, 8'd10}, {8'd200, 8'd10}, {8'd5, 8'd5}, {8'd1, 8'd2}};
    d2 = 4'b1010;
    e2 = '{{8'd10, 8'd200}, {8'd200, 8'd10}, {8'd5, 8'd5}, {8'd2, 8'd1}};
    bus2.in_valid = 1'b1;
    bus2.in_desc = d2[0];
    bus2.in_data = w2[0];
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("n2_early", bus2.out_valid, k >= 2 && k <= 5);
      if (k < 4) begin
        bus2.in_desc = d2[k];
        bus2.in_data = w2[k];
      end else bus2.in_valid = 1'b0;
      if (k >= 2 && k <= 5) begin
        chk("n2_data", bus2.out_data, e2[k-2]);
        chk("n2_median", bus2.out_median, e2[k-2][2*W-1 -: W]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
